uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter DATA_W, default 9, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO words (power of 2, >=2).
REQ-003 SHALL have parameter DIV_W, default 16, baud divisor width.
REQ-004 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port baud_div  input  DIV_W  clock cycles per bit minus 1.
REQ-007 SHALL have port data_len  input  4  data bits per frame; below 5 is treated as 5, above DATA_W as DATA_W.
REQ-008 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 space (parity bit = 0).
REQ-009 SHALL have port stop_bits  input  1  0 one stop bit, 1 two stop bits.
REQ-010 SHALL have port wr_valid  input  1  write request.
REQ-011 SHALL have port wr_data  input  DATA_W  word to transmit, LSB first.
REQ-012 SHALL have port wr_ready  output  1  FIFO can accept a word.
REQ-013 SHALL have port data_out  output  1  serial line, idle high.
REQ-014 SHALL have port tx_active  output  1  frame in progress.
REQ-015 SHALL have port tx_done  output  1  one-cycle pulse at end of frame.
REQ-016 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH+1)  words stored.
REQ-017 SHALL have port fifo_empty  output  1  fifo_level == 0.
REQ-018 SHALL have port fifo_full  output  1  fifo_level == FIFO_DEPTH.

Function
REQ-019 SHALL drive wr_ready = !fifo_full and store wr_data on any edge where wr_valid && wr_ready.
REQ-020 SHALL run FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START pops one FIFO word on the first edge with fifo_empty low.
REQ-021 SHALL make data_out fall on the second rising edge after the edge that accepts a word into an empty FIFO while in IDLE.
REQ-022 SHALL latch baud_div, data_len, parity_type and stop_bits at the pop; changes mid-frame SHALL NOT affect the current frame.
REQ-023 SHALL hold each bit for exactly baud_div+1 cycles; baud_div=0 is legal and gives 1 cycle per bit.
REQ-024 SHALL send start bit 0, then data_len bits LSB first, then a parity bit if parity_type != 00, then 1 or 2 stop bits of 1; wr_data bits above data_len SHALL be ignored.
REQ-025 SHALL compute parity over the data_len transmitted bits only: odd gives an odd total count of ones, even gives an even total count.
REQ-026 SHALL hold tx_active high from START entry through the last stop-bit cycle, and low in IDLE.
REQ-027 SHALL pulse tx_done for exactly the cycle after the last stop-bit cycle, once per frame.
REQ-028 SHALL, at end of STOP with FIFO non-empty, pop and enter START directly with no idle bit; tx_done still pulses, and tx_active stays high.
REQ-029 SHALL, on a write and a pop in the same edge, leave fifo_level unchanged; a pop from a full FIFO raises wr_ready the next cycle.
REQ-030 SHALL wrap read and write pointers modulo FIFO_DEPTH with no loss or duplication.

Reset
REQ-031 SHALL, while rst=0, immediately force data_out=1, tx_active=0, tx_done=0, wr_ready=1, fifo_level=0, fifo_empty=1, fifo_full=0, and FSM=IDLE.
REQ-032 SHALL, on reset mid-frame, abort the frame and flush the FIFO, with no tx_done pulse; operation SHALL resume from IDLE on the first edge after release.

Verification
REQ-033 SHALL cover: baud_div=3, data_len=8, parity 00, 1 stop, write 0xA5 -> data_out 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; 40-cycle frame; one tx_done.
REQ-034 SHALL cover: data_len=7, parity 10, stop_bits=1, write 0x53 -> 7 data bits 1,1,0,0,1,0,1, parity 0, two stop bits; 11-bit frame.
REQ-035 SHALL cover: data_len=9, parity 01, write 0x1FF -> parity bit 0; data_len=9, parity 11, write 0x000 -> parity bit 0.
REQ-036 SHALL cover: baud_div=100, FIFO_DEPTH=8, wr_valid held for 12 words -> wr_ready drops when full; all 12 frames are sent back-to-back with no idle bit in order; 12 tx_done pulses; fifo_level returns to 0.
REQ-037 SHALL cover: baud_div=0, data_len=5, parity 00, 1 stop -> 7-cycle frame; data_len=3 is treated as 5.
REQ-038 SHALL cover: rst=0 during the third data bit with 3 words queued -> data_out=1 and fifo_level=0 immediately; no tx_done; after release, line idle until the next write.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with a per-frame latched format.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module uart_tx_buffered #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic [DIV_W-1:0]                 baud_div,
  input  logic [3:0]                       data_len,
  input  logic [1:0]                       parity_type,
  input  logic                             stop_bits,
  input  logic                             wr_valid,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             wr_ready,
  output logic                             data_out,
  output logic                             tx_active,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             fifo_empty,
  output logic                             fifo_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0] MIN_LEN = 4'd5;
  localparam logic [3:0] MAX_LEN = 4'(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push, pop;
  logic [DATA_W-1:0] rd_word;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d, div_q, div_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d, len_q, len_d, len_in;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [1:0]        par_q, par_d;
  logic              stop_q, stop_d, par_bit_q, par_bit_d;
  logic              ones_par, par_calc, tick;
  logic              frame_end_q, frame_end_d;

  logic              line_d, active_d;
  logic              data_out_q, tx_active_q, tx_done_q;

  assign fifo_level = level_q;
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);
  assign wr_ready   = ~fifo_full;
  assign push       = wr_valid & ~fifo_full;
  assign rd_word    = mem_q[rd_ptr_q];
  assign tick       = (baud_cnt_q == div_q);

  assign data_out   = data_out_q;
  assign tx_active  = tx_active_q;
  assign tx_done    = tx_done_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // Frame format is sampled from the live inputs only at the pop.
  always_comb begin
    if (data_len < MIN_LEN)      len_in = MIN_LEN;
    else if (data_len > MAX_LEN) len_in = MAX_LEN;
    else                         len_in = data_len;
    ones_par = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < len_in) ones_par = ones_par ^ rd_word[i];
    end
    case (parity_type)
      2'b01:   par_calc = ~ones_par;
      2'b10:   par_calc = ones_par;
      default: par_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = '0;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    div_d       = div_q;
    len_d       = len_q;
    par_d       = par_q;
    stop_d      = stop_q;
    par_bit_d   = par_bit_q;
    pop         = 1'b0;
    frame_end_d = 1'b0;
    if (state_q != S_IDLE && !tick) baud_cnt_d = baud_cnt_q + DIV_W'(1);
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == len_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = (par_q == 2'b00) ? S_STOP : S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt_q == {3'b000, stop_q}) begin
            frame_end_d = 1'b1;
            if (!fifo_empty) pop = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d    = S_START;
      baud_cnt_d = '0;
      shreg_d    = rd_word;
      div_d      = baud_div;
      len_d      = len_in;
      par_d      = parity_type;
      stop_d     = stop_bits;
      par_bit_d  = par_calc;
    end
  end

  always_comb begin
    active_d = (state_q != S_IDLE);
    case (state_q)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_q[0];
      S_PARITY: line_d = par_bit_q;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Line outputs are registered, so tx_done lags frame_end by one more cycle.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      div_q       <= '0;
      len_q       <= MIN_LEN;
      par_q       <= 2'b00;
      stop_q      <= 1'b0;
      par_bit_q   <= 1'b0;
      frame_end_q <= 1'b0;
      data_out_q  <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      div_q       <= div_d;
      len_q       <= len_d;
      par_q       <= par_d;
      stop_q      <= stop_d;
      par_bit_q   <= par_bit_d;
      frame_end_q <= frame_end_d;
      data_out_q  <= line_d;
      tx_active_q <= active_d;
      tx_done_q   <= frame_end_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized self-checking bench against a bit-list line model.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_buffered;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [3:0]  data_len;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic        wr_valid;
  logic [8:0]  wr_data;
  logic        wr_ready, data_out, tx_active, tx_done;
  logic [3:0]  fifo_level;
  logic        fifo_empty, fifo_full;

  int n_vec = 0;
  int n_err = 0;

  bit exp_line[$], exp_act[$], exp_done[$];
  bit obs_line[$], obs_act[$], obs_done[$];
  int ends[$];

  logic [8:0] b2b_words[12];
  int         b2b_acc, b2b_not_ready, b2b_budget, b2b_total;
  bit         b2b_ready_now;

  uart_tx_buffered #(.DATA_W(9), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clock(clock), .rst(rst), .baud_div(baud_div), .data_len(data_len),
    .parity_type(parity_type), .stop_bits(stop_bits), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .data_out(data_out),
    .tx_active(tx_active), .tx_done(tx_done), .fifo_level(fifo_level),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: one idle sample, then each frame as a list of bits each
  // stretched to div+1 cycles; tx_done lands on the sample after a frame.
  task automatic model_begin();
    exp_line.delete(); exp_act.delete(); exp_done.delete(); ends.delete();
    exp_line.push_back(1'b1); exp_act.push_back(1'b0); exp_done.push_back(1'b0);
  endtask

  task automatic model_frame(input logic [8:0] word, input int len_in, input int par,
                             input int stp, input int div);
    int len;
    int ones;
    bit bits[$];
    len  = (len_in < 5) ? 5 : ((len_in > 9) ? 9 : len_in);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      bits.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (par == 1)      bits.push_back(bit'(ones % 2 == 0));
    else if (par == 2) bits.push_back(bit'(ones % 2 == 1));
    else if (par == 3) bits.push_back(1'b0);
    for (int s = 0; s <= stp; s++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c <= div; c++) begin
        exp_line.push_back(bits[b]); exp_act.push_back(1'b1); exp_done.push_back(1'b0);
      end
    end
    ends.push_back(exp_line.size());
  endtask

  task automatic model_end(input int total);
    while (exp_line.size() < total) begin
      exp_line.push_back(1'b1); exp_act.push_back(1'b0); exp_done.push_back(1'b0);
    end
    foreach (ends[e]) if (ends[e] < total) exp_done[ends[e]] = 1'b1;
  endtask

  task automatic capture(input int n, input bit scramble);
    obs_line.delete(); obs_act.delete(); obs_done.delete();
    for (int k = 0; k < n; k++) begin
      tick();
      obs_line.push_back(data_out); obs_act.push_back(tx_active); obs_done.push_back(tx_done);
      if (scramble && k == 0) begin
        baud_div    = 16'($urandom);
        data_len    = 4'($urandom);
        parity_type = 2'($urandom);
        stop_bits   = 1'($urandom);
      end
    end
  endtask

  function automatic int first_diff(input bit a[$], input bit b[$]);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    foreach (a[i]) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i]);
    return n;
  endfunction

  task automatic run_single(input logic [8:0] word, input int len, input int par,
                            input int stp, input int div, input bit scramble);
    int total;
    baud_div = 16'(div); data_len = 4'(len); parity_type = 2'(par); stop_bits = 1'(stp);
    model_begin();
    model_frame(word, len, par, stp, div);
    total = exp_line.size() + 4;
    model_end(total);
    wr_valid = 1'b1; wr_data = word;
    tick();
    wr_valid = 1'b0;
    capture(total, scramble);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    n_vec++; if (data_out !== 1'b1)   begin n_err++; $display("FAIL reset_data_out: got %b want 1", data_out); end
    n_vec++; if (tx_active !== 1'b0)  begin n_err++; $display("FAIL reset_tx_active: got %b want 0", tx_active); end
    n_vec++; if (tx_done !== 1'b0)    begin n_err++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_vec++; if (wr_ready !== 1'b1)   begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_vec++; if (fifo_full !== 1'b0)  begin n_err++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int idx;
    int bad;
    bit ref_bits[10];
    ref_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_single(9'h0A5, 8, 0, 0, 3, 1'b0);
    idx = first_diff(obs_line, exp_line);
    n_vec++; if (idx != -1) begin n_err++; $display("FAIL a5_line: cycle %0d got %b want %b", idx, obs_line[idx], exp_line[idx]); end
    idx = first_diff(obs_done, exp_done);
    n_vec++; if (idx != -1) begin n_err++; $display("FAIL a5_done: cycle %0d got %b want %b", idx, obs_done[idx], exp_done[idx]); end
    bad = -1;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 4; c++)
        if (bad == -1 && obs_line[1 + 4*b + c] != ref_bits[b]) bad = b;
    n_vec++; if (bad != -1) begin n_err++; $display("FAIL a5_bit_table: bit %0d got %b want %b", bad, obs_line[1 + 4*bad], ref_bits[bad]); end
    n_vec++; if (count_ones(obs_act) !== 40) begin n_err++; $display("FAIL a5_frame_len: got %0d want 40", count_ones(obs_act)); end
    n_vec++; if (count_ones(obs_done) !== 1) begin n_err++; $display("FAIL a5_done_count: got %0d want 1", count_ones(obs_done)); end
  endtask

  task automatic test_parity_frames();
    logic [8:0] words[3];
    int lens[3], pars[3], stps[3], nbits[3];
    int idx, div, pidx;
    words = '{9'h053, 9'h1FF, 9'h000};
    lens  = '{7, 9, 9};
    pars  = '{2, 1, 3};
    stps  = '{1, 0, 0};
    nbits = '{11, 12, 12};
    for (int t = 0; t < 3; t++) begin
      div = int'($urandom_range(0, 3));
      run_single(words[t], lens[t], pars[t], stps[t], div, 1'b0);
      idx = first_diff(obs_line, exp_line);
      n_vec++; if (idx != -1) begin n_err++; $display("FAIL parity_line[%0d]: cycle %0d got %b want %b", t, idx, obs_line[idx], exp_line[idx]); end
      pidx = 1 + (1 + lens[t]) * (div + 1);
      n_vec++; if (obs_line[pidx] !== 1'b0) begin n_err++; $display("FAIL parity_bit[%0d]: got %b want 0", t, obs_line[pidx]); end
      n_vec++; if (count_ones(obs_act) !== nbits[t] * (div + 1)) begin
        n_err++; $display("FAIL parity_frame_len[%0d]: got %0d want %0d", t, count_ones(obs_act), nbits[t] * (div + 1));
      end
    end
  endtask

  task automatic test_short_frames();
    int idx;
    for (int t = 0; t < 2; t++) begin
      run_single(9'($urandom), (t == 0) ? 5 : 3, 0, 0, 0, 1'b0);
      idx = first_diff(obs_line, exp_line);
      n_vec++; if (idx != -1) begin n_err++; $display("FAIL short_line[%0d]: cycle %0d got %b want %b", t, idx, obs_line[idx], exp_line[idx]); end
      n_vec++; if (count_ones(obs_act) !== 7) begin n_err++; $display("FAIL short_frame_len[%0d]: got %0d want 7", t, count_ones(obs_act)); end
      idx = first_diff(obs_done, exp_done);
      n_vec++; if (idx != -1) begin n_err++; $display("FAIL short_done[%0d]: cycle %0d got %b want %b", t, idx, obs_done[idx], exp_done[idx]); end
    end
  endtask

  task automatic test_random_frames();
    int idx;
    for (int t = 0; t < 20; t++) begin
      run_single(9'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 1'b1);
      idx = first_diff(obs_line, exp_line);
      n_vec++; if (idx != -1) begin n_err++; $display("FAIL rand_line[%0d]: cycle %0d got %b want %b", t, idx, obs_line[idx], exp_line[idx]); end
      idx = first_diff(obs_act, exp_act);
      n_vec++; if (idx != -1) begin n_err++; $display("FAIL rand_active[%0d]: cycle %0d got %b want %b", t, idx, obs_act[idx], exp_act[idx]); end
      idx = first_diff(obs_done, exp_done);
      n_vec++; if (idx != -1) begin n_err++; $display("FAIL rand_done[%0d]: cycle %0d got %b want %b", t, idx, obs_done[idx], exp_done[idx]); end
    end
  endtask

  task test_back_to_back();
    int idx;
    baud_div = 16'd100; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    model_begin();
    for (int i = 0; i < 12; i++) begin
      b2b_words[i] = 9'($urandom);
      model_frame(b2b_words[i], 8, 0, 0, 100);
    end
    b2b_total = exp_line.size() + 4;
    model_end(b2b_total);
    b2b_acc = 0; b2b_not_ready = 0; b2b_budget = 0;
    fork
      begin
        wr_valid = 1'b1; wr_data = b2b_words[0];
        while (b2b_acc < 12 && b2b_budget < 20000) begin
          b2b_ready_now = wr_ready;
          if (!b2b_ready_now) b2b_not_ready++;
          tick();
          b2b_budget++;
          if (b2b_ready_now) begin
            b2b_acc++;
            if (b2b_acc < 12) wr_data = b2b_words[b2b_acc];
          end
        end
        wr_valid = 1'b0;
      end
      begin
        @(posedge clock);
        capture(b2b_total, 1'b0);
      end
    join
    n_vec++; if (b2b_acc !== 12) begin n_err++; $display("FAIL b2b_accepted: got %0d want 12", b2b_acc); end
    n_vec++; if (b2b_not_ready == 0) begin n_err++; $display("FAIL b2b_ready_drop: got %0d stalled cycles want >0", b2b_not_ready); end
    idx = first_diff(obs_line, exp_line);
    n_vec++; if (idx != -1) begin n_err++; $display("FAIL b2b_line: cycle %0d got %b want %b", idx, obs_line[idx], exp_line[idx]); end
    idx = first_diff(obs_act, exp_act);
    n_vec++; if (idx != -1) begin n_err++; $display("FAIL b2b_active: cycle %0d got %b want %b", idx, obs_act[idx], exp_act[idx]); end
    idx = first_diff(obs_done, exp_done);
    n_vec++; if (idx != -1) begin n_err++; $display("FAIL b2b_done: cycle %0d got %b want %b", idx, obs_done[idx], exp_done[idx]); end
    n_vec++; if (count_ones(obs_done) !== 12) begin n_err++; $display("FAIL b2b_done_count: got %0d want 12", count_ones(obs_done)); end
    n_vec++; if (fifo_level !== 4'd0 || fifo_empty !== 1'b1) begin
      n_err++; $display("FAIL b2b_drained: got level %0d empty %b want 0/1", fifo_level, fifo_empty);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w0;
    int bad;
    int idx;
    baud_div = 16'd3; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    w0 = 9'($urandom);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = (i == 0) ? w0 : 9'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    repeat (12) tick();
    n_vec++; if (data_out !== w0[2]) begin n_err++; $display("FAIL rst_mid_bit2: got %b want %b", data_out, w0[2]); end
    n_vec++; if (fifo_level !== 4'd3) begin n_err++; $display("FAIL rst_mid_queued: got %0d want 3", fifo_level); end
    rst = 1'b0;
    #1;
    n_vec++; if (data_out !== 1'b1) begin n_err++; $display("FAIL rst_mid_line: got %b want 1", data_out); end
    n_vec++; if (fifo_level !== 4'd0 || fifo_empty !== 1'b1 || wr_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_flush: got level %0d empty %b ready %b want 0/1/1", fifo_level, fifo_empty, wr_ready);
    end
    n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL rst_mid_active: got %b want 0", tx_active); end
    bad = 0;
    repeat (3) begin tick(); if (tx_done !== 1'b0) bad++; end
    rst = 1'b1;
    repeat (40) begin
      tick();
      if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rst_mid_idle: got %0d bad cycles want 0", bad); end
    run_single(9'($urandom), 8, 2, 1, 1, 1'b0);
    idx = first_diff(obs_line, exp_line);
    n_vec++; if (idx != -1) begin n_err++; $display("FAIL rst_resume_line: cycle %0d got %b want %b", idx, obs_line[idx], exp_line[idx]); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    baud_div = 16'd3; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    test_reset();
    test_basic_frame();
    test_parity_frames();
    test_short_frames();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
